// File: rtl/sw_marker_sequencer.sv
// sw_marker_sequencer: synchronizes the slide switches, picks the lowest
// active switch and walks a single-hot marker from that position down to
// bit 0, pulsing arrive (and counting it) each time bit 0 is reached.
module sw_marker_sequencer #(
  parameter int WIDTH       = 18,
  parameter int IDX_W       = 5,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk18,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             enable,
  output logic [WIDTH-1:0] marker,
  output logic [WIDTH-1:0] sel_onehot,
  output logic [IDX_W-1:0] sel_idx,
  output logic             sel_valid,
  output logic             arrive,
  output logic             date_toggle,
  output logic [CNT_W-1:0] arrive_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    ARRIVE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MARKER_RST = {1'b1, {(WIDTH-1){1'b0}}};

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]                  sw_s;

  logic [WIDTH-1:0] sel_onehot_q, sel_onehot_d;
  logic [IDX_W-1:0] sel_idx_q, sel_idx_d;
  logic             sel_valid_q, sel_valid_d;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] marker_q, marker_d;
  logic             date_toggle_q, date_toggle_d;
  logic [CNT_W-1:0] arrive_cnt_q, arrive_cnt_d;

  // Synchronizer shift chain; the last stage is the clean switch image.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = sw;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign sw_s = sync_q[SYNC_STAGES-1];

  // Lowest-index priority select: first set bit scanning up from bit 0 wins.
  always_comb begin
    sel_onehot_d = '0;
    sel_idx_d    = '0;
    sel_valid_d  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sw_s[i] && !sel_valid_d) begin
        sel_valid_d     = 1'b1;
        sel_onehot_d[i] = 1'b1;
        sel_idx_d       = IDX_W'(i);
      end
    end
  end

  // Marker FSM next state: enable low freezes everything; the switch
  // selection is only consulted when (re)loading from IDLE or ARRIVE.
  always_comb begin
    state_d       = state_q;
    marker_d      = marker_q;
    date_toggle_d = date_toggle_q;
    arrive_cnt_d  = arrive_cnt_q;
    if (enable) begin
      case (state_q)
        SHIFT: begin
          marker_d = marker_q >> 1;
          state_d  = marker_q[1] ? ARRIVE : SHIFT;
        end
        IDLE, ARRIVE: begin
          if (state_q == ARRIVE) begin
            date_toggle_d = ~date_toggle_q;
            if (arrive_cnt_q != {CNT_W{1'b1}}) begin
              arrive_cnt_d = arrive_cnt_q + CNT_W'(1);
            end
          end
          if (sel_valid_q) begin
            marker_d = sel_onehot_q;
            state_d  = sel_onehot_q[0] ? ARRIVE : SHIFT;
          end else begin
            marker_d = '0;
            state_d  = IDLE;
          end
        end
        default: begin
          marker_d = '0;
          state_d  = IDLE;
        end
      endcase
    end
  end

  // State registers; the async reset restarts the walk from the top bit.
  always_ff @(posedge clk18 or posedge rst) begin
    if (rst) begin
      sync_q        <= '0;
      sel_onehot_q  <= '0;
      sel_idx_q     <= '0;
      sel_valid_q   <= 1'b0;
      state_q       <= SHIFT;
      marker_q      <= MARKER_RST;
      date_toggle_q <= 1'b0;
      arrive_cnt_q  <= '0;
    end else begin
      sync_q        <= sync_d;
      sel_onehot_q  <= sel_onehot_d;
      sel_idx_q     <= sel_idx_d;
      sel_valid_q   <= sel_valid_d;
      state_q       <= state_d;
      marker_q      <= marker_d;
      date_toggle_q <= date_toggle_d;
      arrive_cnt_q  <= arrive_cnt_d;
    end
  end

  assign marker      = marker_q;
  assign sel_onehot  = sel_onehot_q;
  assign sel_idx     = sel_idx_q;
  assign sel_valid   = sel_valid_q;
  assign arrive      = enable && (state_q == ARRIVE);
  assign date_toggle = date_toggle_q;
  assign arrive_cnt  = arrive_cnt_q;
  assign busy        = (state_q == SHIFT);

endmodule

// File: tb/tb_sw_marker_sequencer.sv
// Bench for sw_marker_sequencer: stimulus queues hand-computed expectations
// tagged with the clock-edge count; a monitor compares them when due.
module tb_sw_marker_sequencer;

  localparam int S_MARK = 0, S_ARR = 1, S_CNT = 2, S_TOG = 3, S_BUSY = 4,
                 S_OH = 5, S_IDX = 6, S_VLD = 7;

  logic        clk18 = 1'b0;
  logic        rst;
  logic [17:0] sw;
  logic        enable;
  logic [17:0] marker, sel_onehot;
  logic [4:0]  sel_idx;
  logic        sel_valid, arrive, date_toggle, busy;
  logic [7:0]  arrive_cnt;

  sw_marker_sequencer dut (
    .clk18(clk18), .rst(rst), .sw(sw), .enable(enable), .marker(marker),
    .sel_onehot(sel_onehot), .sel_idx(sel_idx), .sel_valid(sel_valid),
    .arrive(arrive), .date_toggle(date_toggle), .arrive_cnt(arrive_cnt),
    .busy(busy)
  );

  always #5 clk18 = ~clk18;

  int cyc = 0;
  always @(posedge clk18) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   base   = 0;
  event sample_ev;

  function automatic logic [31:0] get_sig(int s);
    case (s)
      S_MARK:  return 32'(marker);
      S_ARR:   return 32'(arrive);
      S_CNT:   return 32'(arrive_cnt);
      S_TOG:   return 32'(date_toggle);
      S_BUSY:  return 32'(busy);
      S_OH:    return 32'(sel_onehot);
      S_IDX:   return 32'(sel_idx);
      default: return 32'(sel_valid);
    endcase
  endfunction

  task automatic exp_sig(input int s, input logic [31:0] v, input string n);
    chk_t e;
    e.cyc = cyc; e.sig = s; e.exp = v; e.name = n;
    q.push_back(e);
  endtask

  // Monitor: compares every expectation due at this edge count.
  always begin
    chk_t        e;
    logic [31:0] act;
    @(negedge clk18 or sample_ev);
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s not sampled at edge %0d (now %0d)", e.name, e.cyc, cyc);
      end else begin
        act = get_sig(e.sig);
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s edge %0d: got 0x%0h expected 0x%0h", e.name, cyc - base, act, e.exp);
        end
      end
    end
  end

  task automatic push_reset_checks(input string tag);
    exp_sig(S_MARK, 32'h20000, {tag, "_marker"});
    exp_sig(S_ARR,  0, {tag, "_arrive"});
    exp_sig(S_CNT,  0, {tag, "_cnt"});
    exp_sig(S_TOG,  0, {tag, "_toggle"});
    exp_sig(S_BUSY, 1, {tag, "_busy"});
    exp_sig(S_OH,   0, {tag, "_sel_onehot"});
    exp_sig(S_IDX,  0, {tag, "_sel_idx"});
    exp_sig(S_VLD,  0, {tag, "_sel_valid"});
  endtask

  // Assert reset between edges, check reset values, release; edge n after
  // release is cyc == base + n.
  task automatic do_reset(input logic [17:0] s, input logic en);
    @(negedge clk18);
    #1;
    rst = 1'b1; sw = s; enable = en;
    #1;
    push_reset_checks("rst");
    -> sample_ev;
    #1;
    rst  = 1'b0;
    base = cyc;
  endtask

  task automatic step_to(input int n);
    while (cyc < base + n) begin
      @(posedge clk18);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int m, c;
    rst = 1'b1; sw = '0; enable = 1'b1;

    // Walk from the top bit with no switches set.
    do_reset(18'h0, 1'b1);
    for (int k = 1; k <= 17; k++) begin
      step_to(k);
      exp_sig(S_MARK, 32'(1 << (17 - k)), "t1_marker");
      exp_sig(S_ARR, 32'(k == 17), "t1_arrive");
      exp_sig(S_BUSY, 32'(k < 17), "t1_busy");
    end
    step_to(18);
    exp_sig(S_MARK, 0, "t1_marker_idle");
    exp_sig(S_ARR, 0, "t1_arrive_off");
    exp_sig(S_CNT, 1, "t1_cnt");
    exp_sig(S_TOG, 1, "t1_toggle");
    exp_sig(S_BUSY, 0, "t1_busy_idle");
    step_to(19);
    exp_sig(S_MARK, 0, "t1_idle_hold");
    exp_sig(S_CNT, 1, "t1_cnt_hold");

    // sw=0x4: select latency, then 3-cycle arrive period.
    do_reset(18'h4, 1'b1);
    step_to(2);
    exp_sig(S_VLD, 0, "t2_sel_valid_early");
    step_to(3);
    exp_sig(S_VLD, 1, "t2_sel_valid");
    exp_sig(S_OH, 32'h4, "t2_sel_onehot");
    exp_sig(S_IDX, 2, "t2_sel_idx");
    for (int e = 18; e <= 26; e++) begin
      step_to(e);
      m = (e - 18) % 3;
      c = 1 + (e - 18) / 3;
      exp_sig(S_MARK, (m == 0) ? 32'h4 : (m == 1) ? 32'h2 : 32'h1, "t2_marker");
      exp_sig(S_ARR, 32'(m == 2), "t2_arrive");
      exp_sig(S_CNT, 32'(c), "t2_cnt");
      exp_sig(S_TOG, 32'(c & 1), "t2_toggle");
    end

    // sw=0x1: continuous arrive, counter saturates at 255.
    do_reset(18'h1, 1'b1);
    step_to(16);
    exp_sig(S_ARR, 0, "t3_arrive_before");
    for (int e = 17; e <= 290; e++) begin
      step_to(e);
      c = (e - 17 > 255) ? 255 : e - 17;
      exp_sig(S_MARK, 32'h1, "t3_marker");
      exp_sig(S_ARR, 1, "t3_arrive");
      exp_sig(S_CNT, 32'(c), "t3_cnt");
      exp_sig(S_TOG, 32'((e - 17) & 1), "t3_toggle");
    end

    // sw=0xA0 priority, switch change mid-walk ignored until reload.
    do_reset(18'hA0, 1'b1);
    step_to(3);
    exp_sig(S_OH, 32'h20, "t4_sel_onehot");
    exp_sig(S_IDX, 5, "t4_sel_idx");
    exp_sig(S_VLD, 1, "t4_sel_valid");
    step_to(18);
    exp_sig(S_MARK, 32'h20, "t4_reload");
    step_to(20);
    exp_sig(S_MARK, 32'h08, "t4_marker_08");
    sw = 18'h400;
    step_to(21);
    exp_sig(S_MARK, 32'h04, "t4_walk_04");
    step_to(22);
    exp_sig(S_MARK, 32'h02, "t4_walk_02");
    exp_sig(S_OH, 32'h20, "t4_sel_old");
    step_to(23);
    exp_sig(S_MARK, 32'h01, "t4_walk_01");
    exp_sig(S_ARR, 1, "t4_arrive");
    exp_sig(S_OH, 32'h400, "t4_sel_new");
    exp_sig(S_IDX, 10, "t4_sel_idx_new");
    step_to(24);
    exp_sig(S_MARK, 32'h400, "t4_reload_new");
    exp_sig(S_CNT, 2, "t4_cnt");

    // Freeze with enable=0 at marker 0x100, then resume.
    step_to(26);
    exp_sig(S_MARK, 32'h100, "t5_marker_100");
    enable = 1'b0;
    for (int e = 27; e <= 30; e++) begin
      step_to(e);
      exp_sig(S_MARK, 32'h100, "t5_hold_marker");
      exp_sig(S_ARR, 0, "t5_hold_arrive");
      exp_sig(S_CNT, 2, "t5_hold_cnt");
      exp_sig(S_TOG, 0, "t5_hold_toggle");
      exp_sig(S_BUSY, 1, "t5_hold_busy");
    end
    enable = 1'b1;
    step_to(31);
    exp_sig(S_MARK, 32'h80, "t5_resume");

    // Async reset mid-walk with marker 0x10 and count 7.
    do_reset(18'h10, 1'b1);
    step_to(48);
    exp_sig(S_MARK, 32'h10, "t6_marker_pre");
    exp_sig(S_CNT, 7, "t6_cnt_pre");
    exp_sig(S_TOG, 1, "t6_toggle_pre");
    @(negedge clk18);
    #1;
    rst = 1'b1;
    #1;
    push_reset_checks("t6_async");
    -> sample_ev;
    #1;
    rst = 1'b0;

    @(negedge clk18);
    @(negedge clk18);
    while (q.size() > 0) begin
      chk_t e;
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s never compared", e.name);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
